// File: rtl/soc_system_pio_period_if.sv
// Avalon-MM slave bus for the double-buffered PIO period register block.
interface soc_system_pio_period_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_pio_period.sv
// Double-buffered 24-bit PIO: software edits a shadow copy, a COMMIT write
// transfers it to the fabric-facing active register and pulses out_load.
module soc_system_pio_period (
    input  logic                           clk,
    input  logic                           reset_n,
    soc_system_pio_period_if.slave         bus,
    output logic [23:0]                    out_port,
    output logic                           out_load
);
    localparam logic [2:0] A_SHADOW   = 3'd0;
    localparam logic [2:0] A_COMMIT   = 3'd1;
    localparam logic [2:0] A_ACTIVE   = 3'd2;
    localparam logic [2:0] A_STATUS   = 3'd3;
    localparam logic [2:0] A_OUTSET   = 3'd4;
    localparam logic [2:0] A_OUTCLEAR = 3'd5;

    logic [23:0] r_shadow;
    logic [23:0] r_active;
    logic        r_pending;
    logic [7:0]  r_commit_cnt;
    logic        r_out_load;
    logic [31:0] r_readdata;

    logic        w_wr;
    logic        w_commit;
    logic [23:0] w_wdata;
    logic [31:0] w_rdata;
    logic        w_unused_hi;

    assign w_wr        = bus.chipselect & ~bus.write_n;
    assign w_wdata     = bus.writedata[23:0];
    assign w_commit    = w_wr && (bus.address == A_COMMIT) && bus.writedata[0];
    assign w_unused_hi = ^bus.writedata[31:24];

    // Read mux sees pre-write state, so a same-edge read returns the old value.
    always_comb begin
        w_rdata = 32'd0;
        case (bus.address)
            A_SHADOW: w_rdata = {8'd0, r_shadow};
            A_ACTIVE: w_rdata = {8'd0, r_active};
            A_STATUS: w_rdata = {16'd0, r_commit_cnt, 7'd0, r_pending};
            default:  w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow     <= 24'd0;
            r_active     <= 24'd0;
            r_pending    <= 1'b0;
            r_commit_cnt <= 8'd0;
            r_out_load   <= 1'b0;
            r_readdata   <= 32'd0;
        end else begin
            r_readdata <= w_rdata;
            r_out_load <= w_commit;
            if (w_commit) begin
                r_active     <= r_shadow;
                r_pending    <= 1'b0;
                r_commit_cnt <= r_commit_cnt + 8'd1;
            end else if (w_wr) begin
                case (bus.address)
                    A_SHADOW: begin
                        r_shadow  <= w_wdata;
                        r_pending <= 1'b1;
                    end
                    A_OUTSET: begin
                        r_shadow  <= r_shadow | w_wdata;
                        r_pending <= 1'b1;
                    end
                    A_OUTCLEAR: begin
                        r_shadow  <= r_shadow & ~w_wdata;
                        r_pending <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.readdata = r_readdata;
    assign out_port     = r_active;
    assign out_load     = r_out_load;
endmodule
